// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Purpose:
//   Bit-serial two's-complement subtractor. Computes a - b - borrow_in one bit
//   per clock, LSB first, and presents the result over a valid/ready handshake.
//   Only one operation is in flight at a time. The FSM walks
//   IDLE -> SHIFT (WIDTH cycles) -> DONE -> IDLE.
//
// Parameters:
//   WIDTH       operand/result width in bits, legal range 2..32 (default 4)
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-high reset
//   in_valid    in   1      a, b, borrow_in are valid
//   in_ready    out  1      block can accept operands (registered)
//   a           in   WIDTH  minuend
//   b           in   WIDTH  subtrahend
//   borrow_in   in   1      initial borrow
//   out_valid   out  1      diff, borrow_out, overflow are valid (registered)
//   out_ready   in   1      consumer accepts the result
//   diff        out  WIDTH  a - b - borrow_in modulo 2^WIDTH (registered)
//   borrow_out  out  1      1 when a < b + borrow_in (unsigned, registered)
//   overflow    out  1      signed overflow flag
//
// Configuration:
//   SERIAL_SUB_OVF_EN  when defined, overflow is computed from the captured
//                      operand MSBs and the result MSB and registered with the
//                      result. When undefined, overflow is tied to 0 and no
//                      MSB capture logic exists.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_out_q, borrow_out_d;

`ifdef SERIAL_SUB_OVF_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               overflow_q, overflow_d;
`endif

  // One full-subtractor slice operating on the current operand LSBs.
  logic               a0, b0, d_bit, br_next;
  logic [WIDTH-1:0]   a_shifted;

  always_comb begin
    a0      = a_sr_q[0];
    b0      = b_sr_q[0];
    d_bit   = a0 ^ b0 ^ br_q;
    br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    // The minuend register doubles as the result register: each cycle its
    // consumed LSB drops out and the fresh difference bit enters at the MSB,
    // so after WIDTH shifts it holds the complete difference.
    a_shifted = {d_bit, a_sr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    overflow_d   = overflow_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sr_d     = a;
          b_sr_d     = b;
          br_d       = borrow_in;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d    = a[WIDTH-1];
          b_msb_d    = b[WIDTH-1];
`endif
        end
      end

      SHIFT: begin
        a_sr_d = a_shifted;
        b_sr_d = b_sr_q >> 1;
        br_d   = br_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Final bit: publish the result directly so out_valid rises on
          // this edge, WIDTH edges after the accepting edge.
          diff_d       = a_shifted;
          borrow_out_d = br_next;
          out_valid_d  = 1'b1;
          state_d      = DONE;
`ifdef SERIAL_SUB_OVF_EN
          overflow_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
        end
      end

      DONE: begin
        // in_ready only returns on the handoff edge, so an accept can never
        // coincide with the result handoff.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      overflow_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      br_q         <= br_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      overflow_q   <= overflow_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

`ifdef SERIAL_SUB_OVF_EN
  assign overflow   = overflow_q;
`else
  assign overflow   = 1'b0;
`endif

endmodule
